// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
//   Single-clock FIFO with register-array storage. It buffers cache datapath
//   words between the port ingress logic and the cache arbiter. The FIFO
//   provides run-time almost-full and almost-empty thresholds, an occupancy
//   count, sticky overflow and underflow flags, and a synchronous flush.
//   FWFT_EN selects one of two read modes:
//     FWFT_EN=1  first-word fall-through. The head word is visible on dout
//                with zero latency.
//     FWFT_EN=0  standard registered read. dout arrives one cycle after rd_en.
//
// Ports
//   clk, rst            rising-edge clock; synchronous active-high reset
//   flush               synchronous clear of contents and error flags
//   din, wr_en          write data and write request
//   rd_en               read request
//   dout, dout_valid    read data and its qualifier
//   full, empty         count == DEPTH / count == 0
//   almost_full         count >= af_thresh
//   almost_empty        count <= ae_thresh
//   af_thresh           run-time threshold for almost_full
//   ae_thresh           run-time threshold for almost_empty
//   count               current occupancy, 0..DEPTH
//   overflow            sticky: a write was attempted while the FIFO was full
//   underflow           sticky: a read was attempted while the FIFO was empty
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  almost_empty,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] head;

  assign waddr = wptr[ADDR_WIDTH-1:0];
  assign raddr = rptr[ADDR_WIDTH-1:0];
  assign head  = mem[raddr];

  // Status flags depend only on the registered count and the thresholds.
  // This keeps them glitch-free with respect to wr_en and rd_en.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);

  // When the FIFO is empty, the read is rejected. As a result, a write and a
  // read can never address the same slot in the same cycle.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Pointers, occupancy and sticky flags. Reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  // Storage is not reset. Writes are suppressed during reset and flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_ok) mem[waddr] <= din;
  end

  generate
    if (FWFT_EN) begin : g_fwft
      // last_word holds the most recently popped word.
      // It drives dout whenever the FIFO has nothing to present.
      logic [DATA_WIDTH-1:0] last_word;

      always_ff @(posedge clk) begin
        if (rst) begin
          last_word <= '0;
        end else if (!flush && rd_ok) begin
          last_word <= head;
        end
      end

      assign dout       = empty ? last_word : head;
      assign dout_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      // valid_q is a one-cycle pulse following each accepted read.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) dout_q <= head;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog
//   Drives one FWFT instance and one standard-read instance of sync_fifo_prog
//   from a shared stimulus. Both instances are compared each cycle against a
//   queue-based reference model. The bench also uses a table of hand-derived
//   vectors and several directed multi-cycle sequences.
module tb_sync_fifo_prog;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic [7:0] din;
  logic [4:0] af_thresh, ae_thresh;

  logic       full_f, afull_f, empty_f, aempty_f, valid_f, ovf_f, udf_f;
  logic [7:0] dout_f;
  logic [4:0] count_f;
  logic       full_s, afull_s, empty_s, aempty_s, valid_s, ovf_s, udf_s;
  logic [7:0] dout_s;
  logic [4:0] count_s;

  int checks = 0;
  int errors = 0;

  // Reference model state: contents as a queue plus observable side state.
  logic [7:0] q[$];
  bit         m_ovf, m_udf, m_svalid;
  logic [7:0] m_last, m_sdout;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT_EN(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en),
    .full(full_f), .almost_full(afull_f), .rd_en(rd_en), .dout(dout_f),
    .dout_valid(valid_f), .empty(empty_f), .almost_empty(aempty_f),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count_f),
    .overflow(ovf_f), .underflow(udf_f)
  );

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT_EN(1'b0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .wr_en(wr_en),
    .full(full_s), .almost_full(afull_s), .rd_en(rd_en), .dout(dout_s),
    .dout_valid(valid_s), .empty(empty_s), .almost_empty(aempty_s),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count_s),
    .overflow(ovf_s), .underflow(udf_s)
  );

  typedef struct {
    bit         rst, flush, wr, rd;
    logic [7:0] din;
    logic [4:0] af, ae;
    int         cnt;
    bit         full, empty, afl, ael, ovf, udf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update for one clock edge. The full/empty decisions use the
  // occupancy from before the edge.
  task automatic modelStep();
    int sz;
    sz = q.size();
    if (rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_svalid = 0;
      m_last = 8'h00; m_sdout = 8'h00;
    end else if (flush) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_svalid = 0;
    end else begin
      if (wr_en && sz == DEPTH) m_ovf = 1;
      if (rd_en && sz == 0)     m_udf = 1;
      m_svalid = rd_en && sz != 0;
      if (rd_en && sz != 0) begin
        m_last  = q.pop_front();
        m_sdout = m_last;
      end
      if (wr_en && sz != DEPTH) q.push_back(din);
    end
  endtask

  task automatic checkOutput();
    int         sz;
    logic [7:0] fexp;
    sz   = q.size();
    fexp = (sz > 0) ? q[0] : m_last;
    check("count_fwft",   32'(count_f),  32'(sz));
    check("count_std",    32'(count_s),  32'(sz));
    check("full",         32'(full_f),   32'(sz == DEPTH));
    check("full_std",     32'(full_s),   32'(sz == DEPTH));
    check("empty",        32'(empty_f),  32'(sz == 0));
    check("empty_std",    32'(empty_s),  32'(sz == 0));
    check("almost_full",  32'(afull_f),  32'(sz >= int'(af_thresh)));
    check("almost_empty", 32'(aempty_f), 32'(sz <= int'(ae_thresh)));
    check("afull_std",    32'(afull_s),  32'(sz >= int'(af_thresh)));
    check("aempty_std",   32'(aempty_s), 32'(sz <= int'(ae_thresh)));
    check("overflow",     32'(ovf_f),    32'(m_ovf));
    check("underflow",    32'(udf_f),    32'(m_udf));
    check("ovf_std",      32'(ovf_s),    32'(m_ovf));
    check("udf_std",      32'(udf_s),    32'(m_udf));
    check("dout_fwft",    32'(dout_f),   32'(fexp));
    check("valid_fwft",   32'(valid_f),  32'(sz > 0));
    check("dout_std",     32'(dout_s),   32'(m_sdout));
    check("valid_std",    32'(valid_s),  32'(m_svalid));
  endtask

  // Inputs change on the falling edge. Outputs are checked on the next
  // falling edge, after the rising edge has taken effect.
  task automatic applyStimulus(input bit r, input bit f, input bit w, input bit rd,
                               input logic [7:0] d);
    rst = r; flush = f; wr_en = w; rd_en = rd; din = d;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int af_rise, ae_fall;
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    af_thresh = 5'd14; ae_thresh = 5'd2;
    m_ovf = 0; m_udf = 0; m_svalid = 0; m_last = 8'h00; m_sdout = 8'h00;
    @(negedge clk);

    // Hand-derived vectors:
    //   {rst, flush, wr, rd, din, af, ae, count, full, empty, afull, aempty, ovf, udf}
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd14, 5'd2,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd14, 5'd2,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 5'd14, 5'd2,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 5'd14, 5'd2,  2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 5'd14, 5'd2,  3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0,  5'd2,  3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd17, 5'd16, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd3,  5'd2,  3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 5'd3,  5'd2,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd14, 5'd2,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      af_thresh = vecs[i].af;
      ae_thresh = vecs[i].ae;
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check("vec_count",  32'(count_f),  32'(vecs[i].cnt));
      check("vec_full",   32'(full_f),   32'(vecs[i].full));
      check("vec_empty",  32'(empty_f),  32'(vecs[i].empty));
      check("vec_afull",  32'(afull_f),  32'(vecs[i].afl));
      check("vec_aempty", 32'(aempty_f), 32'(vecs[i].ael));
      check("vec_ovf",    32'(ovf_s),    32'(vecs[i].ovf));
      check("vec_udf",    32'(udf_s),    32'(vecs[i].udf));
    end

    // Fill with 0x00..0x0F and watch the threshold crossings.
    af_thresh = 5'd14; ae_thresh = 5'd2;
    applyStimulus(1, 0, 0, 0, 8'h00);
    af_rise = -1; ae_fall = -1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 1, 0, 8'(i));
      if (afull_f && af_rise < 0)   af_rise = i + 1;
      if (!aempty_f && ae_fall < 0) ae_fall = i + 1;
    end
    check("af_rise_count", 32'(af_rise), 32'd14);
    check("ae_fall_count", 32'(ae_fall), 32'd3);
    check("filled_full",   32'(full_s),  32'd1);

    // Read back 16 words in order.
    for (int i = 0; i < 16; i++) begin
      check("fwft_head",  32'(dout_f),  32'(i));
      check("fwft_valid", 32'(valid_f), 32'd1);
      applyStimulus(0, 0, 0, 1, 8'h00);
      check("std_word",   32'(dout_s),  32'(i));
      check("std_valid",  32'(valid_s), 32'd1);
    end
    check("drained_empty", 32'(empty_f), 32'd1);

    // Simultaneous write and read when full: the read wins and the write is dropped.
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 8'(8'h30 + i));
    applyStimulus(0, 0, 1, 1, 8'hAA);
    check("full_rw_count", 32'(count_f), 32'd15);
    check("full_rw_ovf",   32'(ovf_f),   32'd1);
    check("full_rw_head",  32'(dout_s),  32'h30);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 8'h00);
    check("ovf_sticky", 32'(ovf_s), 32'd1);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 1, 8'h00);

    // Simultaneous write and read when empty: the write wins.
    applyStimulus(0, 0, 1, 1, 8'h55);
    check("empty_rw_udf",   32'(udf_f),   32'd1);
    check("empty_rw_count", 32'(count_s), 32'd1);
    applyStimulus(0, 0, 0, 1, 8'h00);
    check("empty_rw_data",  32'(dout_s),  32'h55);
    applyStimulus(0, 1, 0, 0, 8'h00);

    // Steady concurrent traffic at count=8, enough to wrap both pointers.
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, 1, 1, 8'($urandom));
      check("steady_count", 32'(count_f), 32'd8);
    end
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 8'h00);

    // Flush with a pending write, then reset in the middle of traffic.
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 0, 8'(8'h60 + i));
    for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0, 1, 8'h00);
    check("pre_flush_count", 32'(count_f), 32'd5);
    check("pre_flush_ovf",   32'(ovf_f),   32'd1);
    applyStimulus(0, 1, 1, 0, 8'h77);
    check("flush_count", 32'(count_f), 32'd0);
    check("flush_empty", 32'(empty_s), 32'd1);
    check("flush_ovf",   32'(ovf_f),   32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 8'(8'h80 + i));
    applyStimulus(0, 0, 0, 1, 8'h00);
    applyStimulus(1, 0, 1, 1, 8'h99);
    check("rst_count",      32'(count_s), 32'd0);
    check("rst_dout_fwft",  32'(dout_f),  32'd0);
    check("rst_dout_std",   32'(dout_s),  32'd0);
    check("rst_valid_std",  32'(valid_s), 32'd0);

    // Random traffic, thresholds, flushes and resets against the model.
    for (int i = 0; i < 400; i++) begin
      int sel;
      af_thresh = 5'($urandom_range(0, 17));
      ae_thresh = 5'($urandom_range(0, 17));
      sel = $urandom_range(0, 99);
      applyStimulus(sel == 0, sel == 1 || sel == 2,
                    $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                    8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
